// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer drives data_in/data_in_valid; the transmitter answers with ready.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic                 data_in_valid;
    logic                 ready;

    modport master (output data_in, output data_in_valid, input ready);
    modport slave  (input data_in, input data_in_valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS LSB-first, optional even parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the even-parity bit after the data bits.
module uart_tx #(
    parameter int CLK_HZ      = 66_000_000,
    parameter int BITRATE_BPS = 9_600,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  bus,
    output logic      tx,
    output logic      busy,
    output logic      tx_done
);
    localparam int BIT_CLK = CLK_HZ / BITRATE_BPS;
    localparam int CNT_W   = (BIT_CLK > 1) ? $clog2(BIT_CLK) : 1;
    localparam int IDX_W   = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLK - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic                 stop_idx, stop_idx_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 tx_n;
    logic                 wrap, stop_last, accept;
`ifdef UART_TX_PARITY_EN
    logic                 par, par_n;
`endif

    assign wrap      = (cnt == CNT_LAST);
    // Ready re-opens in the final stop cycle so a waiting byte follows with no idle gap.
    assign stop_last = (state == STOP) && wrap && (stop_idx == 1'(STOP_BITS - 1));
    assign bus.ready = (state == IDLE) || stop_last;
    assign busy      = ~bus.ready;
    assign tx_done   = stop_last;
    assign accept    = bus.data_in_valid && bus.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            sh       <= '0;
            tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            stop_idx <= stop_idx_n;
            sh       <= sh_n;
            tx       <= tx_n;
`ifdef UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = (state == IDLE || wrap) ? '0 : cnt + 1'b1;
        idx_n      = idx;
        stop_idx_n = stop_idx;
        sh_n       = sh;
        tx_n       = tx;
`ifdef UART_TX_PARITY_EN
        par_n      = par;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = START;
                    tx_n    = 1'b0;
                    sh_n    = bus.data_in;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^bus.data_in;
`endif
                end
            end
            START: begin
                if (wrap) begin
                    state_n = DATA;
                    idx_n   = '0;
                    tx_n    = sh[0];
                end
            end
            DATA: begin
                if (wrap) begin
                    if (idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_n    = PARITY;
                        tx_n       = par;
`else
                        state_n    = STOP;
                        stop_idx_n = 1'b0;
                        tx_n       = 1'b1;
`endif
                    end else begin
                        idx_n = idx + 1'b1;
                        sh_n  = sh >> 1;
                        tx_n  = sh[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (wrap) begin
                    state_n    = STOP;
                    stop_idx_n = 1'b0;
                    tx_n       = 1'b1;
                end
            end
`endif
            STOP: begin
                if (stop_last) begin
                    if (accept) begin
                        state_n = START;
                        tx_n    = 1'b0;
                        sh_n    = bus.data_in;
`ifdef UART_TX_PARITY_EN
                        par_n   = ^bus.data_in;
`endif
                    end else begin
                        state_n = IDLE;
                    end
                end else if (wrap) begin
                    stop_idx_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end
endmodule
